led_pwm_fade: RTL
=================

LED_PWM_FADE -- requirements
Module: led_pwm_fade

Interface
REQ-001 Parameter DECAY_DIV, default 781250, is the number of clk cycles per decay tick (15.625 ms at 50 MHz).
REQ-002 Parameter DECAY_STEP, default 8, is the brightness decrement applied per decay tick.
REQ-003 Parameter LED_ACTIVE_LOW, default 0; when 1, led_out is inverted at the output register.
REQ-004 clk  input  1  system clock, 50 MHz; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 led_in  input  [8:1]  raw LED pattern from the LED water stage; 1 = LED commanded on.
REQ-007 led_out  output  [8:1]  PWM drive to the board LEDs, registered.
REQ-008 active  output  1  registered; high while any channel brightness is non-zero.

Function
REQ-009 led_in SHALL be captured into led_q with one register stage every cycle.
REQ-010 pwm_cnt, 8-bit, SHALL increment every cycle and wrap 255 -> 0.
REQ-011 The prescaler SHALL count 0..DECAY_DIV-1 and wrap to 0.
- decay_tick is a 1-cycle pulse in the cycle the prescaler equals DECAY_DIV-1.
REQ-012 Each channel i SHALL hold an 8-bit bright[i] and a state from {OFF, ON, FADE}.
REQ-013 OFF (bright=0): led_q[i]=1 -> ON with bright=255; otherwise stay OFF.
REQ-014 ON (bright=255): led_q[i]=0 -> FADE; bright SHALL stay 255 on the transition cycle.
REQ-015 FADE: led_q[i]=1 -> ON, bright=255, whether or not decay_tick is present (re-light wins).
- Otherwise, on decay_tick: bright = bright - DECAY_STEP, saturating at 0.
- When the result is 0 -> OFF.
- Without decay_tick: bright holds.
REQ-016 Subtraction SHALL be done at 9-bit width; a negative result SHALL clamp to 0, with no wrap to high values.
REQ-017 The raw output bit SHALL be 1 when bright[i]=255 (full on, no PWM gap) or bright[i] > pwm_cnt.
- It is 0 when bright[i]=0.
- It is registered into led_out and XORed with LED_ACTIVE_LOW.
REQ-018 Latency: a led_in bit rising SHALL produce the asserted led_out level 3 cycles later (led_q, bright, led_out).
REQ-019 active SHALL be registered from the OR of (bright[i]!=0) over all channels, in the same cycle as led_out.
REQ-020 Channels SHALL be fully independent; all eight may change state in the same cycle.
REQ-021 The prescaler and pwm_cnt SHALL free-run and never be reset by led_in activity.

Reset
REQ-022 While rst=1, the following SHALL be 0: led_q, pwm_cnt, the prescaler and every bright[i], and every channel SHALL be OFF.
- active=0.
- led_out = all LED_ACTIVE_LOW (LEDs dark).
REQ-023 Reset asserted mid-fade SHALL take effect asynchronously, with no completion of a pending decay step.
REQ-024 After rst deasserts, operation SHALL resume from the REQ-022 values on the next rising clk edge.

Verification (DECAY_DIV=4, DECAY_STEP=64, LED_ACTIVE_LOW=0)
REQ-025 Release reset with led_in=8'h00 for 20 cycles -> led_out=8'h00, active=0 throughout.
REQ-026 Drive led_in=8'h01 steady:
- led_out[1]=1 from cycle 3 onward and stays 1 every cycle (bright=255, no PWM gap).
- active=1.
REQ-027 Drive led_in 8'h01 then 8'h00:
- bright[1] steps 255 -> 191 -> 127 -> 63 -> 0 on successive decay ticks (every 4 cycles).
- The led_out[1] duty per 256-cycle window matches bright/256.
- active falls 1 cycle after bright reaches 0.
REQ-028 Set led_in[1]=1 during FADE in the same cycle as decay_tick -> bright[1]=255 next cycle; no decrement.
REQ-029 Set DECAY_STEP=100 and fade from 255 -> 155, 55, 0 (clamped, no wrap); the channel is OFF afterwards.
REQ-030 Assert rst asynchronously mid-fade with 8'hFF lit -> led_out=8'h00 and active=0 immediately, without waiting for clk.
- With LED_ACTIVE_LOW=1, led_out=8'hFF instead.

Source files
------------

// File: rtl/led_pwm_fade.sv
// Eight-channel LED fader: each lit channel holds full brightness while commanded and then
// decays linearly through a free-running PWM once released.
module led_pwm_fade #(
    parameter int unsigned DECAY_DIV      = 781250,
    parameter int unsigned DECAY_STEP     = 8,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:1] led_in,
    output logic [8:1] led_out,
    output logic       active
);

    typedef enum logic [1:0] {StOff, StOn, StFade} ch_state_e;

    localparam int unsigned    PW        = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DECAY_DIV - 1);
    // Steps beyond 256 behave like 256: any decrement empties the channel.
    localparam logic [8:0]     STEP9     = (DECAY_STEP > 256) ? 9'd256 : 9'(DECAY_STEP);

    logic [8:1]    led_q;
    logic [7:0]    pwm_cnt;
    logic [PW-1:0] presc;
    logic          decay_tick;

    ch_state_e     state_q  [8:1];
    ch_state_e     state_d  [8:1];
    logic [7:0]    bright_q [8:1];
    logic [7:0]    bright_d [8:1];
    logic [8:0]    diff     [8:1];

    logic [8:1]    raw;
    logic          any_lit;

    always_comb decay_tick = (presc == PRESC_MAX);

    always_comb begin
        for (int i = 1; i <= 8; i++) begin
            state_d[i]  = state_q[i];
            bright_d[i] = bright_q[i];
            // Borrow into bit 8 marks an underflow that must clamp to zero.
            diff[i]     = {1'b0, bright_q[i]} - STEP9;
            unique case (state_q[i])
                StOff: begin
                    if (led_q[i]) begin
                        state_d[i]  = StOn;
                        bright_d[i] = 8'hFF;
                    end
                end
                StOn: begin
                    if (!led_q[i]) state_d[i] = StFade;
                end
                StFade: begin
                    if (led_q[i]) begin
                        state_d[i]  = StOn;
                        bright_d[i] = 8'hFF;
                    end else if (decay_tick) begin
                        if (diff[i][8] || (diff[i][7:0] == 8'h00)) begin
                            state_d[i]  = StOff;
                            bright_d[i] = 8'h00;
                        end else begin
                            bright_d[i] = diff[i][7:0];
                        end
                    end
                end
                default: begin
                    state_d[i]  = StOff;
                    bright_d[i] = 8'h00;
                end
            endcase
        end
    end

    always_comb begin
        any_lit = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            raw[i]  = (bright_q[i] == 8'hFF) || (bright_q[i] > pwm_cnt);
            any_lit = any_lit | (bright_q[i] != 8'h00);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= '0;
            pwm_cnt <= '0;
            presc   <= '0;
            led_out <= {8{LED_ACTIVE_LOW}};
            active  <= 1'b0;
            for (int i = 1; i <= 8; i++) begin
                state_q[i]  <= StOff;
                bright_q[i] <= 8'h00;
            end
        end else begin
            led_q   <= led_in;
            pwm_cnt <= pwm_cnt + 8'd1;
            presc   <= decay_tick ? '0 : presc + 1'b1;
            led_out <= raw ^ {8{LED_ACTIVE_LOW}};
            active  <= any_lit;
            for (int i = 1; i <= 8; i++) begin
                state_q[i]  <= state_d[i];
                bright_q[i] <= bright_d[i];
            end
        end
    end

endmodule
